// File: rtl/spi_slave.sv
// SPI mode-0 slave front end: deserialises command frames for the single-port RAM
// and returns its read byte on MISO. Optional SPI_MISO_HIZ_EN tri-states MISO when idle.
module spi_slave #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ss_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int FRAME_W  = ADDR_SIZE + 2;
    localparam int RX_CNT_W = $clog2(FRAME_W + 1);
    localparam int TX_CNT_W = $clog2(ADDR_SIZE + 1);
    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(FRAME_W - 1);
    localparam logic [RX_CNT_W-1:0] RX_FULL = RX_CNT_W'(FRAME_W);
    localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [FRAME_W-2:0]    r_shift;
    logic [RX_CNT_W-1:0]   r_bit_cnt;
    logic [FRAME_W-1:0]    r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rd_addr_loaded;
    logic [ADDR_SIZE-1:0]  r_tx_shift;
    logic [TX_CNT_W-1:0]   r_tx_cnt;
    logic                  r_miso_en;
    logic                  r_miso_bit;
    logic                  r_tx_done;
    logic                  w_frame_done;
    logic                  w_receiving;

    assign w_frame_done = (r_bit_cnt == RX_FULL);
    assign w_receiving  = (r_state != IDLE) && !w_frame_done;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (ss_n) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!mosi)                 w_next_state = WRITE;
                    else if (r_rd_addr_loaded) w_next_state = READ_DATA;
                    else                       w_next_state = READ_ADD;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_shift          <= '0;
            r_bit_cnt        <= '0;
            r_rx_data        <= '0;
            r_rx_valid       <= 1'b0;
            r_rd_addr_loaded <= 1'b0;
            r_tx_shift       <= '0;
            r_tx_cnt         <= '0;
            r_miso_en        <= 1'b0;
            r_miso_bit       <= 1'b0;
            r_tx_done        <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rx_valid <= 1'b0;
            if (ss_n) begin
                // Partial frames and replies are dropped; rx_data and the address flag survive.
                r_bit_cnt  <= '0;
                r_tx_cnt   <= '0;
                r_miso_en  <= 1'b0;
                r_miso_bit <= 1'b0;
                r_tx_done  <= 1'b0;
            end else if (w_receiving) begin
                r_shift   <= {r_shift[FRAME_W-3:0], mosi};
                r_bit_cnt <= r_bit_cnt + RX_CNT_W'(1);
                if (r_bit_cnt == RX_LAST) begin
                    r_rx_data  <= {r_shift, mosi};
                    r_rx_valid <= 1'b1;
                    if (r_state == READ_ADD) r_rd_addr_loaded <= 1'b1;
                end
            end else if (r_state == READ_DATA) begin
                if (r_miso_en) begin
                    if (r_tx_cnt == TX_LAST) begin
                        r_miso_en        <= 1'b0;
                        r_miso_bit       <= 1'b0;
                        r_tx_done        <= 1'b1;
                        r_rd_addr_loaded <= 1'b0;
                    end else begin
                        r_miso_bit <= r_tx_shift[ADDR_SIZE-1];
                        r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
                        r_tx_cnt   <= r_tx_cnt + TX_CNT_W'(1);
                    end
                end else if (!r_tx_done && tx_valid) begin
                    // MSB goes out on the very edge that samples the RAM strobe.
                    r_miso_en  <= 1'b1;
                    r_miso_bit <= tx_data[ADDR_SIZE-1];
                    r_tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                    r_tx_cnt   <= '0;
                end
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

`ifdef SPI_MISO_HIZ_EN
    assign miso = r_miso_en ? r_miso_bit : 1'bz;
`else
    assign miso = r_miso_bit;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized bench for spi_slave against a frame-level model of the
// command/flag/reply rules.
module tb_spi_slave;

    localparam int ADDR_SIZE = 8;
    localparam int FW        = ADDR_SIZE + 2;

`ifdef SPI_MISO_HIZ_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ss_n;
    logic                 mosi;
    logic                 miso;
    logic [FW-1:0]        rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: address-loaded flag and last completed frame.
    bit            m_flag;
    logic [FW-1:0] m_rx;

    spi_slave #(.ADDR_SIZE(ADDR_SIZE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ss_n low edge plus the first n frame bits, MSB first; stray tx_valid pulses thrown in.
    task automatic shift_bits(input logic [FW-1:0] f, input int n, input string tag);
        ss_n = 1'b0;
        mosi = 1'($urandom);
        tick();
        for (int i = FW - 1; i >= FW - n; i--) begin
            mosi     = f[i];
            tx_valid = 1'($urandom);
            tx_data  = 8'($urandom);
            tick();
            if (i > 0) begin
                check_bit({tag, "_rxv_low"}, rx_valid, 1'b0);
                check_bit({tag, "_miso_rx"}, miso, IDLE_MISO);
            end
        end
        tx_valid = 1'b0;
    endtask

    // Complete transaction; the model decides whether a reply must appear.
    task automatic do_frame(input logic [FW-1:0] f, input logic [ADDR_SIZE-1:0] b, input string tag);
        bit rd_data;
        rd_data = f[FW-1] && m_flag;
        shift_bits(f, FW, tag);
        check_bit({tag, "_rxv_pulse"}, rx_valid, 1'b1);
        check_word({tag, "_rx_data"}, rx_data, f);
        m_rx = f;
        if (f[FW-1] && !m_flag) m_flag = 1'b1;
        mosi = 1'($urandom);
        tick();
        check_bit({tag, "_rxv_one_cycle"}, rx_valid, 1'b0);
        check_word({tag, "_rx_hold"}, rx_data, m_rx);
        check_bit({tag, "_miso_wait"}, miso, IDLE_MISO);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        if (rd_data) begin
            for (int k = ADDR_SIZE - 1; k >= 0; k--) begin
                check_bit($sformatf("%s_reply_bit%0d", tag, k), miso, b[k]);
                mosi = 1'($urandom);
                tick();
            end
            m_flag = 1'b0;
            check_bit({tag, "_miso_after_lsb"}, miso, IDLE_MISO);
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            check_bit({tag, "_second_txv_ignored"}, miso, IDLE_MISO);
        end else begin
            for (int k = 0; k < ADDR_SIZE + 1; k++) begin
                check_bit({tag, "_no_reply"}, miso, IDLE_MISO);
                mosi = 1'($urandom);
                tick();
            end
            check_bit({tag, "_rxv_stay_low"}, rx_valid, 1'b0);
        end
        ss_n = 1'b1;
        tick();
        check_bit({tag, "_miso_end"}, miso, IDLE_MISO);
    endtask

    // Read command up to the point where n reply bits have been checked.
    task automatic partial_reply(input logic [FW-1:0] f, input logic [ADDR_SIZE-1:0] b,
                                 input int n, input string tag);
        shift_bits(f, FW, tag);
        check_word({tag, "_rx_data"}, rx_data, f);
        m_rx = f;
        tick();
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
        for (int k = ADDR_SIZE - 1; k > ADDR_SIZE - 1 - n; k--) begin
            check_bit($sformatf("%s_reply_bit%0d", tag, k), miso, b[k]);
            if (k > ADDR_SIZE - n) tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ss_n     = 1'b0;
        mosi     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        m_flag   = 1'b0;
        m_rx     = '0;
        tick();
        tick();
        check_bit("reset_rx_valid", rx_valid, 1'b0);
        check_word("reset_rx_data", rx_data, '0);
        check_bit("reset_miso", miso, IDLE_MISO);
        rst_n    = 1'b1;
        ss_n     = 1'b1;
        tx_valid = 1'b0;
        tick();

        do_frame(10'h0A5, 8'h00, "wr_addr");
        do_frame(10'h13C, 8'h00, "wr_data");
        do_frame(10'h2A5, 8'h00, "rd_addr");
        do_frame(10'h300, 8'h3C, "rd_data");
        do_frame(10'h2C3, 8'h55, "rd_addr_again");

        // Abort a frame after five bits: nothing delivered, flag untouched.
        shift_bits(10'h1FF, 5, "abort");
        ss_n = 1'b1;
        tick();
        check_bit("abort_no_rxv", rx_valid, 1'b0);
        check_word("abort_rx_keep", rx_data, m_rx);
        tick();
        check_bit("abort_no_rxv_late", rx_valid, 1'b0);
        do_frame(10'h3A7, 8'hA6, "after_abort_rd");

        // Reset during the third reply bit.
        do_frame(10'h211, 8'h00, "pre_reset_addr");
        partial_reply(10'h3FF, 8'hD2, 3, "rst_mid");
        rst_n = 1'b0;
        tick();
        check_bit("rst_mid_miso", miso, IDLE_MISO);
        check_bit("rst_mid_rxv", rx_valid, 1'b0);
        check_word("rst_mid_rx_data", rx_data, '0);
        m_flag = 1'b0;
        m_rx   = '0;
        rst_n  = 1'b1;
        ss_n   = 1'b1;
        tick();
        do_frame(10'h244, 8'h99, "post_reset_rd");

        // ss_n high mid-reply keeps the flag, so the next read goes straight to data.
        partial_reply(10'h300, 8'hB4, 2, "ss_mid");
        ss_n = 1'b1;
        tick();
        check_bit("ss_mid_miso", miso, IDLE_MISO);
        check_bit("ss_mid_rxv", rx_valid, 1'b0);
        do_frame(10'h301, 8'h6D, "ss_mid_retry");

        // Flag persists across a write frame.
        do_frame(10'h2A5, 8'h00, "persist_addr");
        do_frame(10'h0FF, 8'h00, "persist_write");
        do_frame(10'h3C0, 8'hE1, "persist_read");

        for (int n = 0; n < 24; n++) begin
            do_frame(10'($urandom), 8'($urandom), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave front end (mode 0, MSB first) that deserialises MOSI frames into parallel command words for the single-port RAM.
- On a read-data command, it returns the RAM's read byte serially on MISO.
- Sits directly upstream of the RAM: drives its din/rx_valid and consumes its dout/tx_valid.
- clk is the SPI serial clock; all logic is single-domain on posedge clk.

Parameters:
ADDR_SIZE, 8, RAM address/data width; command frame is ADDR_SIZE+2 bits, read reply is ADDR_SIZE bits.

Ports:
clk  input  1  SPI serial clock; all sampling and driving on rising edge
rst_n  input  1  reset, synchronous, active-low
ss_n  input  1  slave select, active-low; high frames/aborts a transaction
mosi  input  1  serial data in, sampled on posedge clk
miso  output  1  serial data out, updated on posedge clk
rx_data  output  ADDR_SIZE+2  assembled frame {cmd[1:0], payload[ADDR_SIZE-1:0]} to RAM din
rx_valid  output  1  one-cycle strobe: rx_data holds a complete new frame
tx_data  input  ADDR_SIZE  read byte from RAM dout
tx_valid  input  1  RAM strobe: tx_data valid

Behaviour:
- Reset (rst_n low at posedge) forces the following, with priority over ss_n:
  - state = IDLE; rx_data = 0; rx_valid = 0; miso = 0.
  - Bit counters = 0; rd_addr_loaded flag = 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Any state, ss_n sampled high -> IDLE next edge; counters cleared.
  - A partial frame is discarded: no rx_valid, rx_data unchanged, rd_addr_loaded unchanged.
- IDLE -> CHK_CMD when ss_n sampled low. No mosi bit is captured on that edge; the master presents bit 9 on the following cycle.
- CHK_CMD samples mosi as frame bit ADDR_SIZE+1 (command MSB) and branches:
  - 0 -> WRITE.
  - 1 and rd_addr_loaded=0 -> READ_ADD.
  - 1 and rd_addr_loaded=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA each shift in the remaining ADDR_SIZE+1 bits, MSB first, one per edge.
- On the edge capturing the final bit:
  - rx_data is loaded with all ADDR_SIZE+2 bits.
  - rx_valid = 1 for exactly one cycle, then 0.
  - rx_data holds until the next complete frame.
- The mosi-supplied bit ADDR_SIZE is passed through unchanged. The slave does not police it against the state; the RAM decodes rx_data[ADDR_SIZE+1:ADDR_SIZE].
- After a complete frame, WRITE and READ_ADD stay put, ignoring mosi, until ss_n goes high. READ_ADD sets rd_addr_loaded=1 when its frame completes.
- READ_DATA after frame completion:
  - Waits for tx_valid; tx_valid outside this wait window is ignored.
  - On the first edge with tx_valid=1: tx_data is latched and miso = tx_data[ADDR_SIZE-1] on that edge.
  - The next ADDR_SIZE-1 edges drive the remaining bits, MSB to LSB.
  - After the LSB: rd_addr_loaded cleared; miso returns to 0; wait for ss_n high.
  - Further tx_valid pulses are ignored.
- Frame timing, ADDR_SIZE=8:
  - ss_n low edge, then 10 bit edges; rx_valid high on the cycle after the 10th bit.
  - RAM tx_valid arrives one edge later; first MISO bit appears on the edge where tx_valid is sampled.
- ss_n high mid-reply aborts the transfer:
  - miso = 0.
  - rd_addr_loaded stays 1, so the next read-command frame again goes to READ_DATA.
- miso = 0 whenever not actively shifting reply bits.

Optional Feature:
- Macro SPI_MISO_HIZ_EN.
- Defined: miso = 1'bz whenever not actively shifting reply bits (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA wait/done, abort, reset), so multiple slaves can share one MISO line.
- Undefined: miso is driven 0 in those cases, as specified above.

Test Plan:
- Write address: reset, ss_n low, shift 10'b00_1010_0101, ss_n high -> rx_data=10'h0A5, rx_valid high exactly 1 cycle after bit 10; miso stays 0.
- Write data: then shift 10'b01_0011_1100 -> rx_data=10'h13C, one-cycle rx_valid; rd_addr_loaded still 0.
- Read sequence:
  - Shift 10'b10_1010_0101 -> READ_ADD taken, rx_data=10'h2A5, flag set.
  - Next frame 10'b11_0000_0000 with RAM model returning tx_valid + 8'h3C one cycle after rx_valid -> miso serial 0,0,1,1,1,1,0,0 on consecutive edges starting at the tx_valid edge; flag cleared.
- Abort: ss_n high after 5 bits of 10'h1FF -> no rx_valid, rx_data keeps prior value, state IDLE next edge.
- Reset mid-reply: rst_n low during 3rd MISO bit -> next edge miso=0, rx_valid=0, rx_data=0, flag=0, state IDLE.
- Flag persistence: READ_ADD frame, then a WRITE frame 10'h0FF, then read command -> READ_DATA branch taken (flag unaffected by writes).
